// File: rtl/gray_counter_n.sv
// gray_counter_n: parametrised up/down Gray-code counter
// with parallel Gray load and sticky or pulsed overflow.
module gray_counter_n #(
  parameter int WIDTH  = 3,
  parameter bit STICKY = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Clear,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Wrap
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap;

  // Gray to binary: bit i is the XOR of LoadVal[WIDTH-1:i].
  for (genvar g = 0; g < WIDTH; g++) begin : g_g2b
    assign w_load_bin[g] = ^(LoadVal >> g);
  end

  // Next count and wrap detection; Load outranks En.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_wrap    = 1'b0;
    if (Load) begin
      w_cnt_nxt = w_load_bin;
    end else if (En) begin
      if (Up) begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_wrap    = &r_cnt;
      end else begin
        w_cnt_nxt = r_cnt - 1'b1;
        w_wrap    = ~|r_cnt;
      end
    end
  end

  // Binary count and one-cycle wrap pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap;
    end
  end

  if (STICKY) begin : g_sticky
    logic r_ovf;
    // Sticky overflow; a wrap on the same edge beats Clear.
    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)      r_ovf <= 1'b0;
      else if (w_wrap) r_ovf <= 1'b1;
      else if (Clear)  r_ovf <= 1'b0;
    end
    assign Overflow = r_ovf;
  end else begin : g_pulse
    assign Overflow = r_wrap;
  end

  assign Output = r_cnt ^ (r_cnt >> 1);
  assign Binary = r_cnt;
  assign Wrap   = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n: directed checks on three
// configurations (3/sticky, 4/pulse, 8/sticky).
module tb_gray_counter_n;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic       Up;
  logic       Load;
  logic       Clear;
  logic [2:0] lv3;
  logic [3:0] lv4;
  logic [7:0] lv8;
  logic [2:0] g3, b3;
  logic [3:0] g4, b4;
  logic [7:0] g8, b8;
  logic       o3, w3, o4, w4, o8, w8;

  int n_tests = 0;
  int n_fail  = 0;

  gray_counter_n #(.WIDTH(3), .STICKY(1'b1)) u3 (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
    .Load(Load), .LoadVal(lv3), .Clear(Clear),
    .Output(g3), .Binary(b3),
    .Overflow(o3), .Wrap(w3)
  );

  gray_counter_n #(.WIDTH(4), .STICKY(1'b0)) u4 (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
    .Load(Load), .LoadVal(lv4), .Clear(Clear),
    .Output(g4), .Binary(b4),
    .Overflow(o4), .Wrap(w4)
  );

  gray_counter_n #(.WIDTH(8), .STICKY(1'b1)) u8 (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
    .Load(Load), .LoadVal(lv8), .Clear(Clear),
    .Output(g8), .Binary(b8),
    .Overflow(o8), .Wrap(w8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    En = 1'b0; Up = 1'b1;
    Load = 1'b0; Clear = 1'b0;
    step();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    En = 1'b0; Up = 1'b1; Load = 1'b0; Clear = 1'b0;
    lv3 = '0; lv4 = '0; lv8 = '0;
    step();
    step();
    n_tests++;
    if ({g3, b3, o3, w3} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_w3 got=%h want=00", {g3, b3, o3, w3});
    end
    n_tests++;
    if ({g4, b4, o4, w4} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_w4 got=%h want=000", {g4, b4, o4, w4});
    end
    n_tests++;
    if ({g8, b8, o8, w8} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_w8 got=%h want=0", {g8, b8, o8, w8});
    end
    Reset = 1'b1;
  endtask

  task automatic test_up_count();
    logic [2:0] exp_g [8];
    logic [2:0] prev;
    exp_g = '{3'b001, 3'b011, 3'b010, 3'b110,
              3'b111, 3'b101, 3'b100, 3'b000};
    En = 1'b1; Up = 1'b1;
    prev = g3;
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++;
      if (g3 !== exp_g[i]) begin
        n_fail++;
        $display("FAIL up_gray[%0d] got=%b want=%b", i, g3, exp_g[i]);
      end
      n_tests++;
      if ($countones(prev ^ g3) != 1) begin
        n_fail++;
        $display("FAIL up_onebit[%0d] got=%b prev=%b want=1 bit", i, g3, prev);
      end
      n_tests++;
      if (w3 !== (i == 7)) begin
        n_fail++;
        $display("FAIL up_wrap[%0d] got=%b want=%b", i, w3, i == 7);
      end
      n_tests++;
      if (o3 !== (i == 7)) begin
        n_fail++;
        $display("FAIL up_ovf[%0d] got=%b want=%b", i, o3, i == 7);
      end
      prev = g3;
    end
    step();
    n_tests++;
    if ({g3, o3, w3} !== 5'b001_1_0) begin
      n_fail++;
      $display("FAIL up_after_wrap got=%b want=00110", {g3, o3, w3});
    end
    En = 1'b0;
  endtask

  task automatic test_down_underflow();
    do_reset();
    En = 1'b1; Up = 1'b0;
    step();
    n_tests++;
    if ({g3, b3, w3, o3} !== 8'b100_111_1_1) begin
      n_fail++;
      $display("FAIL down_first got=%b want=10011111", {g3, b3, w3, o3});
    end
    step();
    n_tests++;
    if ({g3, b3, w3, o3} !== 8'b101_110_0_1) begin
      n_fail++;
      $display("FAIL down_second got=%b want=10111001", {g3, b3, w3, o3});
    end
    En = 1'b0;
  endtask

  task automatic test_load_priority();
    do_reset();
    Load = 1'b1; lv3 = 3'b110;
    En = 1'b1; Up = 1'b1;
    step();
    n_tests++;
    if ({g3, b3, w3, o3} !== 8'b110_100_0_0) begin
      n_fail++;
      $display("FAIL load_val got=%b want=11010000", {g3, b3, w3, o3});
    end
    step();
    n_tests++;
    if ({g3, b3, w3} !== 7'b110_100_0) begin
      n_fail++;
      $display("FAIL load_same got=%b want=1101000", {g3, b3, w3});
    end
    Load = 1'b0;
    step();
    n_tests++;
    if ({g3, b3} !== 6'b111_101) begin
      n_fail++;
      $display("FAIL load_then_count got=%b want=111101", {g3, b3});
    end
    lv3 = 3'b111;
    Load = 1'b1; En = 1'b0;
    step();
    n_tests++;
    if ({g3, b3, w3, o3} !== 8'b111_101_0_0) begin
      n_fail++;
      $display("FAIL load_no_wrap got=%b want=11110100", {g3, b3, w3, o3});
    end
    Load = 1'b0;
  endtask

  task automatic test_sticky_clear();
    do_reset();
    En = 1'b1; Up = 1'b0;
    step();
    Load = 1'b1; lv3 = 3'b100;
    En = 1'b0; Clear = 1'b1;
    step();
    n_tests++;
    if ({g3, b3, o3} !== 7'b100_111_0) begin
      n_fail++;
      $display("FAIL clr_setup got=%b want=1001110", {g3, b3, o3});
    end
    Load = 1'b0;
    En = 1'b1; Up = 1'b1; Clear = 1'b1;
    step();
    n_tests++;
    if ({g3, w3, o3} !== 5'b000_1_1) begin
      n_fail++;
      $display("FAIL clr_race got=%b want=00011", {g3, w3, o3});
    end
    En = 1'b0; Clear = 1'b1;
    step();
    n_tests++;
    if ({g3, w3, o3} !== 5'b000_0_0) begin
      n_fail++;
      $display("FAIL clr_alone got=%b want=00000", {g3, w3, o3});
    end
    step();
    n_tests++;
    if ({g3, w3, o3} !== 5'b000_0_0) begin
      n_fail++;
      $display("FAIL clr_idle got=%b want=00000", {g3, w3, o3});
    end
    Clear = 1'b0;
  endtask

  task automatic test_pulse_mode();
    int pulses;
    logic [3:0] eb;
    logic [3:0] eg;
    do_reset();
    En = 1'b1; Up = 1'b1; Clear = 1'b1;
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      eb = 4'((i + 1) % 16);
      eg = eb ^ (eb >> 1);
      if (o4) pulses++;
      n_tests++;
      if (g4 !== eg || b4 !== eb) begin
        n_fail++;
        $display("FAIL pulse_cnt[%0d] got=%b/%h want=%b/%h", i, g4, b4, eg, eb);
      end
      n_tests++;
      if (o4 !== (eb == 4'd0) || w4 !== (eb == 4'd0)) begin
        n_fail++;
        $display("FAIL pulse_flag[%0d] got=%b%b want=%b%b", i, o4, w4, eb == 0, eb == 0);
      end
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL pulse_count got=%0d want=2", pulses);
    end
    En = 1'b0; Clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    En = 1'b1; Up = 1'b1;
    step();
    Up = 1'b0;
    n_tests++;
    if ({g3, w3} !== 4'b001_0) begin
      n_fail++;
      $display("FAIL rev_up got=%b want=0010", {g3, w3});
    end
    step();
    n_tests++;
    if ({g3, b3, w3} !== 7'b000_000_0) begin
      n_fail++;
      $display("FAIL rev_down got=%b want=0000000", {g3, b3, w3});
    end
    step();
    n_tests++;
    if ({g3, b3, w3, o3} !== 8'b100_111_1_1) begin
      n_fail++;
      $display("FAIL rev_under got=%b want=10011111", {g3, b3, w3, o3});
    end
    En = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    Load = 1'b1; lv8 = 8'h77;
    step();
    Load = 1'b0;
    n_tests++;
    if ({g8, b8} !== 16'h775A) begin
      n_fail++;
      $display("FAIL async_setup got=%h want=775a", {g8, b8});
    end
    En = 1'b1; Up = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    n_tests++;
    if ({g8, b8, o8, w8} !== 18'h0) begin
      n_fail++;
      $display("FAIL async_clear got=%h want=0", {g8, b8, o8, w8});
    end
    #2;
    Reset = 1'b1;
    step();
    n_tests++;
    if ({g8, b8, w8} !== 17'h00202) begin
      n_fail++;
      $display("FAIL async_release got=%h/%h want=01/01", g8, b8);
    end
    En = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_underflow();
    test_load_priority();
    test_sticky_clear();
    test_pulse_mode();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
